// File: rtl/time_bcd_display.sv
// Sequential double-dabble binary-to-BCD converter driving active-low seven-segment digits.
// One binary bit is consumed per clock; the displayed value only updates when a conversion ends.
module time_bcd_display #(
    parameter int unsigned IN_WIDTH      = 26,
    parameter int unsigned DIGITS        = 8,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic                    load,
    input  logic [IN_WIDTH-1:0]     binIn,
    output logic                    busy,
    output logic                    done,
    output logic [4*DIGITS-1:0]     bcdOut,
    output logic [7*DIGITS-1:0]     hexOut
);

    localparam int unsigned SW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(IN_WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e              state_q, state_d;
    logic [IN_WIDTH-1:0] bin_q, bin_d;
    logic [SW-1:0]       scratch_q, scratch_d;
    logic [SW-1:0]       bcd_q, bcd_d;
    logic [CW-1:0]       count_q, count_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [SW-1:0]       scratch_adj;
    logic [SW-1:0]       scratch_next;

    // Add-3 correction on every digit in parallel, then shift in the next binary MSB.
    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        scratch_next = (scratch_adj << 1) | {{(SW-1){1'b0}}, bin_q[IN_WIDTH-1]};
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (load) begin
                    state_d   = StShift;
                    bin_d     = binIn;
                    scratch_d = '0;
                    count_d   = CW'(IN_WIDTH);
                    busy_d    = 1'b1;
                end
            end
            StShift: begin
                scratch_d = scratch_next;
                bin_d     = bin_q << 1;
                count_d   = count_q - 1'b1;
                if (count_q == CW'(1)) begin
                    state_d = StDone;
                    bcd_d   = scratch_next;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= StIdle;
            bin_q     <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        unique case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Walk from the most significant digit down; a digit is dark while everything above is zero.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        hexOut     = '1;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (bcd_q[4*k +: 4] == 4'd0);
            if (BLANK_LEADING && (k > 0) && upper_zero) begin
                hexOut[7*k +: 7] = 7'b1111111;
            end else begin
                hexOut[7*k +: 7] = seg7(bcd_q[4*k +: 4]);
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign bcdOut = bcd_q;

endmodule
